// File: rtl/reg_sb_pkg.sv
// reg_sb_pkg
// Shared definitions for the register scoreboard: register-file geometry,
// the register-address type and a one-hot helper.
package reg_sb_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One-hot mask with the bit for register 'addr' set.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
// Bundles the decode-side issue request, the writeback report, the flush
// strobe and the scoreboard's responses.
//   master : pipeline side (drives issue_*, wb_*, flush; reads stall,
//            busy_vec, err_underflow)
//   slave  : scoreboard side (the reverse)
interface reg_scoreboard_if;
    import reg_sb_pkg::*;

    logic                issue_valid;
    reg_addr_t           issue_rs;
    reg_addr_t           issue_rt;
    logic                issue_uses_rt;
    logic                issue_wr_en;
    reg_addr_t           issue_rd;
    logic                wb_valid;
    reg_addr_t           wb_rd;
    logic                flush;
    logic                stall;
    logic [NUM_REGS-1:0] busy_vec;
    logic                err_underflow;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_uses_rt,
               issue_wr_en, issue_rd, wb_valid, wb_rd, flush,
        input  stall, busy_vec, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_uses_rt,
               issue_wr_en, issue_rd, wb_valid, wb_rd, flush,
        output stall, busy_vec, err_underflow
    );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter
// Per-register pending-write counter: saturating up/down with synchronous
// clear. Also keeps a registered "count is nonzero" flag so the busy
// indication comes straight from a flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear to zero at next edge (wins over inc/dec)
//   inc, dec   : count up / down; both together leave the count unchanged
//   count      : current pending count
//   busy       : registered (count != 0)
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             busy_reg;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !dec && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_W'(1);
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            busy_reg  <= |count_next;
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Register-file scoreboard for an in-order pipeline. Counts in-flight writes
// per architectural register, stalls decode on a RAW hazard or when a
// destination counter is full, and flags writebacks that have no matching
// pending write.
//   clk, rst_n : clock, asynchronous active-low reset
//   sb         : reg_scoreboard_if.slave (issue_*, wb_*, flush in;
//                stall [combinational], busy_vec, err_underflow out)
//   CNT_W      : pending counter width (max 2^CNT_W-1 writes per register)
// Build option: define SB_WB_BYPASS_EN to let a source whose single pending
// write is being written back this cycle issue without stalling.
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_scoreboard_if.slave       sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Register 0 has no counter; its entry is tied to zero so it can never
    // look pending (sources) or full (destination).
    logic [CNT_W-1:0]    pend [NUM_REGS];
    logic [NUM_REGS-1:0] busy_w;
    logic [NUM_REGS-1:1] inc_vec;
    logic [NUM_REGS-1:1] dec_vec;

    logic rs_hazard;
    logic rt_hazard;
    logic rd_full;
    logic stall_w;
    logic accept;
    logic underflow_hit;
    logic err_reg;

    assign pend[0]   = '0;
    assign busy_w[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            assign inc_vec[gi] = accept && sb.issue_wr_en &&
                                 (sb.issue_rd == reg_addr_t'(gi));
            assign dec_vec[gi] = sb.wb_valid && (sb.wb_rd == reg_addr_t'(gi));

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (sb.flush),
                .inc   (inc_vec[gi]),
                .dec   (dec_vec[gi]),
                .count (pend[gi]),
                .busy  (busy_w[gi])
            );
        end
    endgenerate

`ifdef SB_WB_BYPASS_EN
    // A source whose only outstanding write retires this very cycle can take
    // the writeback value from the bypass path instead of waiting.
    assign rs_hazard = (pend[sb.issue_rs] != '0) &&
                       !(sb.wb_valid && (sb.wb_rd == sb.issue_rs) &&
                         (pend[sb.issue_rs] == CNT_W'(1)));
    assign rt_hazard = (pend[sb.issue_rt] != '0) &&
                       !(sb.wb_valid && (sb.wb_rd == sb.issue_rt) &&
                         (pend[sb.issue_rt] == CNT_W'(1)));
`else
    assign rs_hazard = (pend[sb.issue_rs] != '0);
    assign rt_hazard = (pend[sb.issue_rt] != '0);
`endif

    // The destination check deliberately ignores a same-cycle writeback:
    // a full counter always blocks, keeping the increment path free of wrap.
    assign rd_full = (pend[sb.issue_rd] == CNT_MAX);

    assign stall_w = sb.issue_valid &&
                     (sb.flush || rs_hazard ||
                      (sb.issue_uses_rt && rt_hazard) ||
                      (sb.issue_wr_en && rd_full));

    assign accept = sb.issue_valid && !stall_w && !sb.flush;

    // A writeback with nothing pending is an error, except in a flush cycle
    // where all bookkeeping is being discarded anyway.
    assign underflow_hit = !sb.flush && sb.wb_valid &&
                           (sb.wb_rd != '0) && (pend[sb.wb_rd] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (underflow_hit) begin
            err_reg <= 1'b1;
        end
    end

    assign sb.stall         = stall_w;
    assign sb.busy_vec      = busy_w;
    assign sb.err_underflow = err_reg;

endmodule
